// File: rtl/rdma_cq_pkg.sv
// Shared definitions for the RDMA completion-queue engine: status codes and
// the bit layout of one CQ entry.
package rdma_cq_pkg;

    typedef enum logic [1:0] {
        STS_OK        = 2'd0,
        STS_RETRY_EXC = 2'd1,
        STS_REM_ERR   = 2'd2,
        STS_FLUSH     = 2'd3
    } cq_status_e;

    localparam int STS_W = 2;

    // CQ entry layout, LSB first: status, wr_id, qpn.
    localparam int ENTRY_STS_LSB  = 0;
    localparam int ENTRY_WRID_LSB = ENTRY_STS_LSB + STS_W;

    function automatic int entry_qpn_lsb(input int wrid_w);
        return ENTRY_WRID_LSB + wrid_w;
    endfunction

    function automatic int entry_width(input int qpn_w, input int wrid_w);
        return entry_qpn_lsb(wrid_w) + qpn_w;
    endfunction

endpackage

// File: rtl/rdma_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among pending requests, priority starts
// at the requester after the last grant (requester 0 after reset).
module rdma_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int PW = $clog2(N);
    localparam logic [PW:0] N_L = (PW+1)'(N);

    logic [PW-1:0] ptr;
    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;
    logic          any;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PW'(i);
                any = 1'b1;
            end
        end
        sum       = {1'b0, ptr} + {1'b0, off};
        grant_idx = (sum >= N_L) ? PW'(sum - N_L) : sum[PW-1:0];
        grant     = '0;
        if (en && any) grant[grant_idx] = 1'b1;
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rdma_cq_engine.sv
// Completion-queue engine: per-QP staging slots, round-robin merge into a
// first-word-fall-through completion queue with per-QP drop flags.
module rdma_cq_engine
    import rdma_cq_pkg::*;
#(
    parameter int NUM_QP = 4,
    parameter int DEPTH  = 8,
    parameter int WRID_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_QP-1:0]           tx_done,
    input  logic [NUM_QP*WRID_W-1:0]    tx_wr_id,
    input  logic [NUM_QP*2-1:0]         tx_status,
    output logic                        comp_valid,
    input  logic                        comp_ready,
    output logic [$clog2(NUM_QP)-1:0]   comp_qpn,
    output logic [WRID_W-1:0]           comp_wr_id,
    output logic [1:0]                  comp_status,
    output logic [$clog2(DEPTH):0]      cq_count,
    output logic [NUM_QP-1:0]           ovf,
    input  logic [NUM_QP-1:0]           ovf_clr
);
    localparam int QPN_W   = $clog2(NUM_QP);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_width(QPN_W, WRID_W);
    localparam int QPN_LSB = entry_qpn_lsb(WRID_W);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WRID_W-1:0]  slot_wr_id  [NUM_QP];
    logic [STS_W-1:0]   slot_status [NUM_QP];
    logic [NUM_QP-1:0]  pend;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [NUM_QP-1:0]  grant;
    logic [QPN_W-1:0]   grant_idx;
    logic               push;
    logic               pop;
    logic               can_grant;
    logic [ENTRY_W-1:0] head;

    assign comp_valid = (count != '0);
    assign pop        = comp_valid && comp_ready;
    assign can_grant  = (count != FULL_CNT) || pop;
    assign push       = |grant;

    rdma_rr_arbiter #(.N(NUM_QP)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pend),
        .en        (can_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A granted slot is free to reload in the same cycle; a busy one drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            for (int q = 0; q < NUM_QP; q++) begin
                if (grant[q])        pend[q] <= tx_done[q];
                else if (tx_done[q]) pend[q] <= 1'b1;

                if (tx_done[q] && pend[q] && !grant[q]) ovf[q] <= 1'b1;
                else if (ovf_clr[q])                    ovf[q] <= 1'b0;
            end
        end
    end

    // NOTE: slot and queue storage carry no reset; pend and the pointers
    // decide what is valid, and the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        for (int q = 0; q < NUM_QP; q++) begin
            if (tx_done[q] && (grant[q] || !pend[q])) begin
                slot_wr_id[q]  <= tx_wr_id[q*WRID_W +: WRID_W];
                slot_status[q] <= tx_status[q*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {grant_idx, slot_wr_id[grant_idx], slot_status[grant_idx]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head        = comp_valid ? mem[rd_ptr] : '0;
    assign comp_status = head[ENTRY_STS_LSB +: STS_W];
    assign comp_wr_id  = head[ENTRY_WRID_LSB +: WRID_W];
    assign comp_qpn    = head[QPN_LSB +: QPN_W];
    assign cq_count    = count;

endmodule

// File: tb/tb_rdma_cq_engine.sv
// Directed bench for rdma_cq_engine: latency, arbitration order, backpressure,
// overflow, grant/reload collision and mid-stream reset.
module tb_rdma_cq_engine;
    import rdma_cq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  tx_done;
    logic [63:0] tx_wr_id;
    logic [7:0]  tx_status;
    logic        comp_valid;
    logic        comp_ready;
    logic [1:0]  comp_qpn;
    logic [15:0] comp_wr_id;
    logic [1:0]  comp_status;
    logic [3:0]  cq_count;
    logic [3:0]  ovf;
    logic [3:0]  ovf_clr;

    int tests = 0;
    int fails = 0;

    // Expected entries: {qpn, status, wr_id}.
    logic [19:0] exp_q[$];
    logic [19:0] e;

    rdma_cq_engine #(.NUM_QP(4), .DEPTH(8), .WRID_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_done     (tx_done),
        .tx_wr_id    (tx_wr_id),
        .tx_status   (tx_status),
        .comp_valid  (comp_valid),
        .comp_ready  (comp_ready),
        .comp_qpn    (comp_qpn),
        .comp_wr_id  (comp_wr_id),
        .comp_status (comp_status),
        .cq_count    (cq_count),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        tx_done    = '0;
        ovf_clr    = '0;
        comp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One-cycle completion on every QP in mask; QP q gets wr_id base+q and
    // status 3-q, so status never equals qpn.
    task automatic complete(input logic [3:0] mask, input logic [15:0] base);
        for (int q = 0; q < 4; q++) begin
            tx_wr_id[q*16 +: 16] = base + 16'(q);
            tx_status[q*2 +: 2]  = 2'(3 - q);
        end
        tx_done = mask;
        tick();
        tx_done = '0;
    endtask

    task automatic push_exp(input logic [1:0] q, input logic [15:0] id);
        exp_q.push_back({q, 2'(3 - q), id});
    endtask

    // Two full rounds of four completions each, from an empty queue.
    task automatic fill8(input logic [15:0] base);
        complete(4'hF, base);
        repeat (4) tick();
        complete(4'hF, base + 16'd4);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) push_exp(2'(i % 4), base + 16'(i));
    endtask

    task automatic drain(input string tag);
        comp_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " valid"},  32'(comp_valid),  32'd1);
            check({tag, " qpn"},    32'(comp_qpn),    32'(e[19:18]));
            check({tag, " status"}, 32'(comp_status), 32'(e[17:16]));
            check({tag, " wr_id"},  32'(comp_wr_id),  32'(e[15:0]));
            tick();
        end
        comp_ready = 1'b0;
        check({tag, " empty count"}, 32'(cq_count),   32'd0);
        check({tag, " empty valid"}, 32'(comp_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        tx_done    = '0;
        tx_wr_id   = '0;
        tx_status  = '0;
        comp_ready = 1'b0;
        ovf_clr    = '0;

        // Reset state and idle pop.
        do_reset();
        check("rst valid",  32'(comp_valid),  32'd0);
        check("rst count",  32'(cq_count),    32'd0);
        check("rst ovf",    32'(ovf),         32'd0);
        check("rst qpn",    32'(comp_qpn),    32'd0);
        check("rst wr_id",  32'(comp_wr_id),  32'd0);
        check("rst status", 32'(comp_status), 32'd0);
        comp_ready = 1'b1;
        tick();
        check("idle pop count", 32'(cq_count), 32'd0);

        // Single completion on QP2, two-edge latency.
        do_reset();
        comp_ready        = 1'b1;
        tx_wr_id[32 +: 16] = 16'h1234;
        tx_status[4 +: 2]  = STS_OK;
        tx_done            = 4'b0100;
        tick();
        tx_done = '0;
        check("single edge1 valid", 32'(comp_valid), 32'd0);
        tick();
        check("single valid",  32'(comp_valid),  32'd1);
        check("single qpn",    32'(comp_qpn),    32'd2);
        check("single wr_id",  32'(comp_wr_id),  32'h1234);
        check("single status", 32'(comp_status), 32'(STS_OK));
        check("single count",  32'(cq_count),    32'd1);
        tick();
        check("single drained count", 32'(cq_count),   32'd0);
        check("single drained valid", 32'(comp_valid), 32'd0);

        // Simultaneous completions: one grant per cycle in QP order.
        do_reset();
        complete(4'hF, 16'h0010);
        check("simul count0", 32'(cq_count), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("simul count", 32'(cq_count), 32'(i));
        end
        for (int i = 0; i < 4; i++) push_exp(2'(i), 16'h0010 + 16'(i));
        drain("simul");

        // Backpressure: 8 queued, 2 staged, then release in grant order.
        do_reset();
        fill8(16'h0020);
        complete(4'b0011, 16'h0028);
        tick();
        tick();
        check("full count", 32'(cq_count),   32'd8);
        check("full ovf",   32'(ovf),        32'd0);
        check("full valid", 32'(comp_valid), 32'd1);
        push_exp(2'd0, 16'h0028);
        push_exp(2'd1, 16'h0029);
        drain("backpressure");

        // Overflow on QP1 while full and staged; clear, then set-beats-clear.
        do_reset();
        fill8(16'h0020);
        complete(4'b0010, 16'h0100);
        check("ovf staged", 32'(ovf), 32'd0);
        complete(4'b0010, 16'hBEEE);
        check("ovf set",   32'(ovf),      32'b0010);
        check("ovf count", 32'(cq_count), 32'd8);
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = '0;
        check("ovf clear", 32'(ovf), 32'd0);
        ovf_clr = 4'b0010;
        complete(4'b0010, 16'hBEEE);
        ovf_clr = '0;
        check("ovf set wins", 32'(ovf), 32'b0010);
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = '0;
        check("ovf clear again", 32'(ovf), 32'd0);
        push_exp(2'd1, 16'h0101);
        drain("overflow");
        tick();
        tick();
        check("overflow no extra", 32'(comp_valid), 32'd0);

        // Grant of QP0 coincides with a new completion on QP0.
        do_reset();
        complete(4'b0001, 16'h00A0);
        complete(4'b0001, 16'h00A1);
        tick();
        check("collide count", 32'(cq_count), 32'd2);
        check("collide ovf",   32'(ovf),      32'd0);
        push_exp(2'd0, 16'h00A0);
        push_exp(2'd0, 16'h00A1);
        drain("collide");

        // Reset with five queued entries; completions during reset ignored.
        do_reset();
        complete(4'hF, 16'h0040);
        repeat (4) tick();
        complete(4'b0001, 16'h0050);
        tick();
        check("midrst pre count", 32'(cq_count), 32'd5);
        rst     = 1'b1;
        tx_done = 4'hF;
        tick();
        rst     = 1'b0;
        tx_done = '0;
        check("midrst valid", 32'(comp_valid), 32'd0);
        check("midrst count", 32'(cq_count),   32'd0);
        check("midrst ovf",   32'(ovf),        32'd0);
        tick();
        tick();
        check("midrst ignored done", 32'(cq_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rdma_cq_engine.md
RDMA_CQ_ENGINE -- requirements
Module: rdma_cq_engine

Interface
REQ-001 SHALL have parameter NUM_QP, default 4: number of request channels (QPs), 2..16.
REQ-002 SHALL have parameter DEPTH, default 8: completion-queue entries, power of two, 2..64.
REQ-003 SHALL have parameter WRID_W, default 16: work-request id width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port tx_done, input, NUM_QP: per-QP one-cycle pulse, request finished.
REQ-007 SHALL have port tx_wr_id, input, NUM_QP*WRID_W: per-QP wr id, slice q at [q*WRID_W +: WRID_W], valid with tx_done[q].
REQ-008 SHALL have port tx_status, input, NUM_QP*2: per-QP 2-bit completion status, valid with tx_done[q].
REQ-009 SHALL have port comp_valid, output, 1: CQ head entry valid.
REQ-010 SHALL have port comp_ready, input, 1: host accepts the head entry.
REQ-011 SHALL have port comp_qpn, output, clog2(NUM_QP): QP number of the head entry.
REQ-012 SHALL have port comp_wr_id, output, WRID_W: wr id of the head entry.
REQ-013 SHALL have port comp_status, output, 2: status of the head entry.
REQ-014 SHALL have port cq_count, output, clog2(DEPTH)+1: entries held in the CQ.
REQ-015 SHALL have port ovf, output, NUM_QP: per-QP sticky drop flag.
REQ-016 SHALL have port ovf_clr, input, NUM_QP: per-bit clear for ovf.

Function
REQ-017 SHALL hold one staging slot per QP; tx_done[q] loads wr_id/status into slot q and sets pend[q].
REQ-018 SHALL use a round-robin arbiter over pend; at most one grant per cycle; priority starts at the QP after the last grant; after reset QP0 is highest.
REQ-019 SHALL grant only when cq_count<DEPTH or a pop occurs in the same cycle.
REQ-020 SHALL write the granted slot {qpn, wr_id, status} into the CQ at the edge ending the grant cycle and clear pend[q], unless REQ-021 applies.
REQ-021 SHALL, when tx_done[q] and a grant of q coincide, enqueue the old slot contents and reload the slot with new data, keeping pend[q]=1.
REQ-022 SHALL, on tx_done[q] with pend[q]=1 and no grant of q, drop the new completion, keep the slot unchanged and set ovf[q].
REQ-023 SHALL clear ovf[q] on ovf_clr[q]; a set event in the same cycle wins.
REQ-024 SHALL present the CQ as first-word-fall-through: comp_valid=1 iff cq_count>0; the head fields are stable while comp_valid=1 and comp_ready=0.
REQ-025 SHALL pop on comp_valid&&comp_ready; push and pop in one cycle leave cq_count unchanged; this is legal at full and at 1 entry.
REQ-026 SHALL give 2-cycle latency: tx_done at edge N, CQ empty, no contention -> comp_valid=1 after edge N+2.
REQ-027 SHALL keep CQ order equal to grant order; read and write pointers wrap modulo DEPTH.
REQ-028 SHALL treat comp_ready with comp_valid=0 as a no-op.

Reset
REQ-029 SHALL, on rst, clear pend, ovf, pointers and the arbiter priority to 0, giving comp_valid=0 and cq_count=0; comp_qpn/comp_wr_id/comp_status SHALL read 0.
REQ-030 SHALL discard staged and queued entries on rst asserted mid-operation; tx_done during rst SHALL be ignored.

Structure
REQ-031 SHALL take status encodings from shared package rdma_cq_pkg: STS_OK=0, STS_RETRY_EXC=1, STS_REM_ERR=2, STS_FLUSH=3, plus the CQ entry field layout.
REQ-032 SHALL implement arbitration in sub-module rdma_rr_arbiter (NUM_QP request bits in, one-hot grant out, registered priority pointer).
REQ-033 SHALL keep CQ storage as an internal register array, with no vendor macro.

Verification
REQ-034 SHALL cover single completion: tx_done[2], wr_id=0x1234, STS_OK, comp_ready=1 -> comp_valid after 2 edges, qpn=2, wr_id=0x1234, then cq_count=0.
REQ-035 SHALL cover simultaneous completions: tx_done=4'b1111 at once, ids 0x10..0x13 -> CQ order QP0,1,2,3 over 4 consecutive grant cycles.
REQ-036 SHALL cover backpressure and full: comp_ready=0, 10 completions spread over QPs -> cq_count=8, 2 held in staging, ovf=0; raise comp_ready -> all 10 delivered in grant order.
REQ-037 SHALL cover overflow: CQ full, QP1 staged, second tx_done[1] id=0xBEEF -> ovf[1]=1, 0xBEEF never delivered; ovf_clr[1] -> ovf[1]=0.
REQ-038 SHALL cover grant/reload collision: tx_done[0] in the same cycle as QP0 is granted -> both old and new ids delivered, ovf[0]=0.
REQ-039 SHALL cover reset mid-stream: rst with cq_count=5 -> next cycle comp_valid=0, cq_count=0, ovf=0.
